// File: rtl/zx_mem_mapper.sv
// ZX Spectrum paging unit: snoops OUTs to 7FFD/1FFD and maps CPU addresses
// onto physical RAM/ROM, with 128K, Pentagon 256/512 and +3 special modes.
module zx_mem_mapper #(
   parameter int RAM_BANK_BITS = 3,
   parameter int ENABLE_1FFD   = 1,
   parameter int FULL_DECODE   = 0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [15:0]               A,
   input  logic [7:0]                D,
   input  logic                      nMREQ,
   input  logic                      nIORQ,
   input  logic                      nWR,
   input  logic                      nM1,
   output logic [RAM_BANK_BITS+13:0] mem_addr,
   output logic [15:0]               rom_addr,
   output logic                      mem_rom,
   output logic                      ram_we,
   output logic                      vid_page,
   output logic [7:0]                port_7ffd,
   output logic [7:0]                port_1ffd,
   output logic                      locked
);

   logic                     io_wr;
   logic                     io_wr_d;
   logic                     wr_event;
   logic                     hit_7ffd;
   logic                     hit_1ffd;
   logic                     pend_7ffd_reg;
   logic                     pend_1ffd_reg;
   logic [7:0]               wr_data_reg;
   logic [7:0]               port_7ffd_reg;
   logic [7:0]               port_1ffd_reg;
   logic [RAM_BANK_BITS-1:0] c000_bank;
   logic [RAM_BANK_BITS-1:0] bank;
   logic [2:0]               special_bank;

   // nM1 low with nIORQ low is an interrupt acknowledge, never a port write
   assign io_wr    = ~nIORQ & ~nWR & nM1;
   assign wr_event = io_wr & ~io_wr_d;

   generate
      if (FULL_DECODE != 0) begin : g_full_decode
         assign hit_7ffd = (A == 16'h7FFD);
         assign hit_1ffd = (A == 16'h1FFD);
      end else begin : g_partial_decode
         assign hit_7ffd = (A[15:14] == 2'b01)   && !A[1];
         assign hit_1ffd = (A[15:12] == 4'b0001) && !A[1];
      end
   endgenerate

   // Address/data are captured on the edge-detect clock and committed one
   // clock later, so a long-held strobe cannot re-trigger or pick up late data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         io_wr_d       <= 1'b0;
         pend_7ffd_reg <= 1'b0;
         pend_1ffd_reg <= 1'b0;
         wr_data_reg   <= 8'h00;
         port_7ffd_reg <= 8'h00;
         port_1ffd_reg <= 8'h00;
      end else begin
         io_wr_d       <= io_wr;
         pend_7ffd_reg <= wr_event & hit_7ffd;
         pend_1ffd_reg <= wr_event & hit_1ffd & (ENABLE_1FFD != 0);
         if (wr_event) begin
            wr_data_reg <= D;
         end
         if (pend_7ffd_reg && !port_7ffd_reg[5]) begin
            port_7ffd_reg <= wr_data_reg;
         end
         if (pend_1ffd_reg && !port_7ffd_reg[5]) begin
            port_1ffd_reg <= wr_data_reg;
         end
      end
   end

   assign port_7ffd = port_7ffd_reg;
   assign port_1ffd = port_1ffd_reg;
   assign locked    = port_7ffd_reg[5];
   assign vid_page  = port_7ffd_reg[3];

   // Extra high bank bits come from the Pentagon-style 7FFD bits 6 and 7
   generate
      if (RAM_BANK_BITS == 3) begin : g_bank_128k
         assign c000_bank = port_7ffd_reg[2:0];
      end else if (RAM_BANK_BITS == 4) begin : g_bank_256k
         assign c000_bank = {port_7ffd_reg[6], port_7ffd_reg[2:0]};
      end else begin : g_bank_512k
         assign c000_bank = {port_7ffd_reg[7], port_7ffd_reg[6], port_7ffd_reg[2:0]};
      end
   endgenerate

   always_comb begin
      special_bank = 3'd0;
      case ({port_1ffd_reg[2:1], A[15:14]})
         4'b00_00: special_bank = 3'd0;
         4'b00_01: special_bank = 3'd1;
         4'b00_10: special_bank = 3'd2;
         4'b00_11: special_bank = 3'd3;
         4'b01_00: special_bank = 3'd4;
         4'b01_01: special_bank = 3'd5;
         4'b01_10: special_bank = 3'd6;
         4'b01_11: special_bank = 3'd7;
         4'b10_00: special_bank = 3'd4;
         4'b10_01: special_bank = 3'd5;
         4'b10_10: special_bank = 3'd6;
         4'b10_11: special_bank = 3'd3;
         4'b11_00: special_bank = 3'd4;
         4'b11_01: special_bank = 3'd7;
         4'b11_10: special_bank = 3'd6;
         default:  special_bank = 3'd3;
      endcase
   end

   always_comb begin
      bank    = '0;
      mem_rom = 1'b0;
      if (port_1ffd_reg[0]) begin
         bank[2:0] = special_bank;
      end else begin
         case (A[15:14])
            2'b00:   mem_rom = 1'b1;
            2'b01:   bank[2:0] = 3'd5;
            2'b10:   bank[2:0] = 3'd2;
            default: bank = c000_bank;
         endcase
      end
   end

   assign mem_addr = {bank, A[13:0]};
   assign rom_addr = {port_1ffd_reg[2], port_7ffd_reg[4], A[13:0]};
   assign ram_we   = ~nMREQ & ~nWR & ~mem_rom;

endmodule

// File: tb/tb_zx_mem_mapper.sv
// Directed bench for zx_mem_mapper: a 128K instance, a 512K instance and a
// full-decode instance without 1FFD all watch the same Z80 bus.
module tb_zx_mem_mapper;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] A = 16'h0000;
   logic [7:0]  D = 8'h00;
   logic        nMREQ = 1'b1;
   logic        nIORQ = 1'b1;
   logic        nWR = 1'b1;
   logic        nM1 = 1'b1;

   logic [16:0] a_mem_addr;
   logic [15:0] a_rom_addr;
   logic        a_mem_rom, a_ram_we, a_vid_page, a_locked;
   logic [7:0]  a_p7, a_p1;

   logic [18:0] b_mem_addr;
   logic [15:0] b_rom_addr;
   logic        b_mem_rom, b_ram_we, b_vid_page, b_locked;
   logic [7:0]  b_p7, b_p1;

   logic [16:0] c_mem_addr;
   logic [15:0] c_rom_addr;
   logic        c_mem_rom, c_ram_we, c_vid_page, c_locked;
   logic [7:0]  c_p7, c_p1;

   int total = 0;
   int bad = 0;

   always #20 clock = ~clock;

   zx_mem_mapper #(.RAM_BANK_BITS(3), .ENABLE_1FFD(1), .FULL_DECODE(0)) dut (
      .clock(clock), .reset_n(reset_n), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
      .nWR(nWR), .nM1(nM1), .mem_addr(a_mem_addr), .rom_addr(a_rom_addr),
      .mem_rom(a_mem_rom), .ram_we(a_ram_we), .vid_page(a_vid_page),
      .port_7ffd(a_p7), .port_1ffd(a_p1), .locked(a_locked));

   zx_mem_mapper #(.RAM_BANK_BITS(5), .ENABLE_1FFD(1), .FULL_DECODE(0)) dut512 (
      .clock(clock), .reset_n(reset_n), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
      .nWR(nWR), .nM1(nM1), .mem_addr(b_mem_addr), .rom_addr(b_rom_addr),
      .mem_rom(b_mem_rom), .ram_we(b_ram_we), .vid_page(b_vid_page),
      .port_7ffd(b_p7), .port_1ffd(b_p1), .locked(b_locked));

   zx_mem_mapper #(.RAM_BANK_BITS(3), .ENABLE_1FFD(0), .FULL_DECODE(1)) dut_fd (
      .clock(clock), .reset_n(reset_n), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
      .nWR(nWR), .nM1(nM1), .mem_addr(c_mem_addr), .rom_addr(c_rom_addr),
      .mem_rom(c_mem_rom), .ram_we(c_ram_we), .vid_page(c_vid_page),
      .port_7ffd(c_p7), .port_1ffd(c_p1), .locked(c_locked));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
      $display("check %-22s observed=%h expected=%h", tag, got, exp);
   endtask

   task automatic peek(input logic [15:0] a);
      A = a;
      #1;
   endtask

   task automatic io_out(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock);
      A = a; D = d; nM1 = 1'b1; nIORQ = 1'b0; nWR = 1'b0;
      @(negedge clock);
      @(negedge clock);
      nIORQ = 1'b1; nWR = 1'b1;
      @(negedge clock);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst_async_p7", {24'h0, a_p7}, 32'h00);
      chk("rst_async_lock", {31'h0, a_locked}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Reset state
      peek(16'h0123);
      chk("rst_mem_rom", {31'h0, a_mem_rom}, 32'h1);
      chk("rst_rom_addr", {16'h0, a_rom_addr}, 32'h0123);
      peek(16'hC010);
      chk("rst_c000_addr", {15'h0, a_mem_addr}, 32'h00010);
      chk("rst_vid_page", {31'h0, a_vid_page}, 32'h0);
      chk("rst_locked", {31'h0, a_locked}, 32'h0);
      chk("rst_p1", {24'h0, a_p1}, 32'h00);

      // OUT 7FFD,1B with one clock of commit latency
      @(negedge clock);
      A = 16'h7FFD; D = 8'h1B; nIORQ = 1'b0; nWR = 1'b0;
      @(negedge clock);
      chk("p7_not_yet", {24'h0, a_p7}, 32'h00);
      @(negedge clock);
      chk("p7_latency1", {24'h0, a_p7}, 32'h1B);
      nIORQ = 1'b1; nWR = 1'b1;
      @(negedge clock);
      peek(16'hC000);
      chk("bank3_c000", {15'h0, a_mem_addr}, 32'h0C000);
      chk("bank3_c000_512", {13'h0, b_mem_addr}, 32'h0C000);
      chk("fd_bank3_c000", {15'h0, c_mem_addr}, 32'h0C000);
      chk("vid_page_1", {31'h0, a_vid_page}, 32'h1);
      peek(16'h0000);
      chk("rom_bank1", {16'h0, a_rom_addr}, 32'h4000);

      // RAM write enable: dropped for ROM, asserted for bank 2
      nMREQ = 1'b0; nWR = 1'b0;
      peek(16'h0005);
      chk("rom_we_dropped", {31'h0, a_ram_we}, 32'h0);
      peek(16'h8123);
      chk("ram_we_8000", {31'h0, a_ram_we}, 32'h1);
      chk("bank2_8000", {15'h0, a_mem_addr}, 32'h08123);
      peek(16'h4001);
      chk("bank5_4000", {15'h0, a_mem_addr}, 32'h14001);
      nMREQ = 1'b1; nWR = 1'b1;

      // Lock: locking write accepted, later writes ignored until reset
      io_out(16'h7FFD, 8'h20);
      chk("lock_set", {31'h0, a_locked}, 32'h1);
      io_out(16'h7FFD, 8'h07);
      chk("locked_p7", {24'h0, a_p7}, 32'h20);
      io_out(16'h1FFD, 8'h07);
      chk("locked_p1", {24'h0, a_p1}, 32'h00);
      peek(16'hC000);
      chk("locked_bank0", {15'h0, a_mem_addr}, 32'h00000);
      chk("locked_vid0", {31'h0, a_vid_page}, 32'h0);
      pulse_reset();
      chk("unlocked", {31'h0, a_locked}, 32'h0);

      // 1FFD: ROM high bit, then special all-RAM mode 11
      io_out(16'h1FFD, 8'h04);
      peek(16'h0000);
      chk("rom_bank2", {16'h0, a_rom_addr}, 32'h8000);
      chk("fd_no_1ffd", {24'h0, c_p1}, 32'h00);
      io_out(16'h1FFD, 8'h07);
      chk("p1_07", {24'h0, a_p1}, 32'h07);
      peek(16'h0000);
      chk("sp_rom_off", {31'h0, a_mem_rom}, 32'h0);
      chk("sp_bank4", {15'h0, a_mem_addr}, 32'h10000);
      chk("fd_still_rom", {31'h0, c_mem_rom}, 32'h1);
      peek(16'h4000);
      chk("sp_bank7", {15'h0, a_mem_addr}, 32'h1C000);
      peek(16'h8000);
      chk("sp_bank6", {15'h0, a_mem_addr}, 32'h18000);
      peek(16'hC000);
      chk("sp_bank3", {15'h0, a_mem_addr}, 32'h0C000);
      chk("sp_rom_off_c000", {31'h0, a_mem_rom}, 32'h0);
      nMREQ = 1'b0; nWR = 1'b0;
      peek(16'h0005);
      chk("sp_ram_we", {31'h0, a_ram_we}, 32'h1);
      nMREQ = 1'b1; nWR = 1'b1;
      pulse_reset();

      // Pentagon-512 high bank bits
      io_out(16'h7FFD, 8'hC5);
      peek(16'hC000);
      chk("p512_bank29", {13'h0, b_mem_addr}, 32'h74000);
      chk("p128_bank5", {15'h0, a_mem_addr}, 32'h14000);

      // Partial decode accepts 7FFC, full decode ignores it
      io_out(16'h7FFC, 8'h01);
      chk("partial_7ffc", {24'h0, a_p7}, 32'h01);
      chk("full_7ffc_ign", {24'h0, c_p7}, 32'hC5);

      // Held strobe: data changed mid-hold must not be picked up
      @(negedge clock);
      A = 16'h7FFD; D = 8'h03; nIORQ = 1'b0; nWR = 1'b0;
      repeat (5) @(negedge clock);
      D = 8'h04;
      repeat (35) @(negedge clock);
      nIORQ = 1'b1; nWR = 1'b1;
      @(negedge clock);
      chk("held_one_event", {24'h0, a_p7}, 32'h03);

      // Interrupt acknowledge is not a port write
      @(negedge clock);
      A = 16'h7FFD; D = 8'h06; nM1 = 1'b0; nIORQ = 1'b0; nWR = 1'b0;
      repeat (3) @(negedge clock);
      nM1 = 1'b1; nIORQ = 1'b1; nWR = 1'b1;
      @(negedge clock);
      chk("m1_no_update", {24'h0, a_p7}, 32'h03);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/zx_mem_mapper.md
Name: zx_mem_mapper

Overview:
- Parametrised ZX Spectrum memory paging unit that replaces the fixed 128K address decode in the top level.
- Snoops Z80 I/O writes to ports 7FFD and 1FFD and holds the paging registers, including the lock.
- Translates each CPU address into a physical RAM or ROM address, a RAM write enable and a video page select.
- Supports 128K, Pentagon-256/512 extended banking and the +3 all-RAM special modes.

Parameters:
- RAM_BANK_BITS, 3: physical RAM bank index width; 3=128K, 4=256K, 5=512K; legal range 3..5.
- ENABLE_1FFD, 1: 1 enables the port 1FFD register; 0 makes it read as zero and ignores writes to it.
- FULL_DECODE, 0: 1 requires an exact 16-bit port match; 0 uses +3 partial decode.

Ports:
- clock in 1: system clock (25 MHz domain).
- reset_n in 1: asynchronous, active-low reset.
- A in 16: Z80 address bus.
- D in 8: Z80 data bus (CPU-driven value).
- nMREQ in 1: Z80 memory request, active low.
- nIORQ in 1: Z80 I/O request, active low.
- nWR in 1: Z80 write strobe, active low.
- nM1 in 1: Z80 M1, active low (used to exclude interrupt acknowledge).
- mem_addr out RAM_BANK_BITS+14: physical RAM address.
- rom_addr out 16: physical ROM address, {rom_bank[1:0], A[13:0]}.
- mem_rom out 1: 1 when the current address maps to ROM.
- ram_we out 1: RAM write enable.
- vid_page out 1: 0 selects screen bank 5, 1 selects bank 7.
- port_7ffd out 8: 7FFD register value.
- port_1ffd out 8: 1FFD register value.
- locked out 1: paging lock, equal to port_7ffd[5].

Behaviour:
- Reset: asynchronous; port_7ffd=0, port_1ffd=0, locked=0, internal io_wr_d=0. Resulting outputs: vid_page=0, rom bank 0, bank 0 at C000.
- Write detect:
  - io_wr = ~nIORQ & ~nWR & nM1.
  - A write event fires on the clock where io_wr=1 and io_wr_d=0 (rising edge); io_wr_d is io_wr registered.
  - Exactly one event per I/O write cycle, regardless of CPU clock ratio.
  - A and D are sampled on the event clock; registers update on the following edge (1-cycle latency).
- Decode, FULL_DECODE=0:
  - 7FFD when A[15:14]=01 and A[1]=0.
  - 1FFD when A[15:12]=0001 and A[1]=0.
- Decode, FULL_DECODE=1: exact matches A=16'h7FFD and A=16'h1FFD only.
- Lock:
  - While locked=1, all writes to both ports are ignored until reset.
  - A write that sets D[5]=1 is itself accepted, so its other bits take effect.
- 1FFD with ENABLE_1FFD=0: writes ignored; port_1ffd stays 0.
- Normal mode (port_1ffd[0]=0):
  - 0000-3FFF: mem_rom=1, rom_bank={port_1ffd[2], port_7ffd[4]}.
  - 4000-7FFF: bank 5.
  - 8000-BFFF: bank 2.
  - C000-FFFF: bank = {hi, port_7ffd[2:0]}.
  - hi is empty for RAM_BANK_BITS=3, port_7ffd[6] for 4, and {port_7ffd[7], port_7ffd[6]} for 5.
- Special mode (port_1ffd[0]=1): mem_rom=0 everywhere; banks are selected by port_1ffd[2:1], listed for 0000/4000/8000/C000:
  - 00: 0, 1, 2, 3.
  - 01: 4, 5, 6, 7.
  - 10: 4, 5, 6, 3.
  - 11: 4, 7, 6, 3.
- Address formation:
  - mem_addr = {bank zero-extended to RAM_BANK_BITS, A[13:0]}.
  - mem_addr and rom_addr are combinational from A and the registers; both are always driven.
- Write enable: ram_we = ~nMREQ & ~nWR & ~mem_rom, combinational. ROM writes are dropped.
- Video page: vid_page = port_7ffd[3], always; lock does not block it.
- Simultaneous events: an io_wr edge coincident with reset assertion loses; reset wins.
- Held strobe: io_wr held low for many cycles produces a single event.

Test Plan:
- Reset, then A=16'h0123 -> mem_rom=1, rom_addr=16'h0123; A=16'hC010 -> mem_addr=17'h00010; vid_page=0; locked=0.
- OUT 7FFD with D=8'h1B, then A=16'hC000 -> mem_addr bank 3; rom_addr[15:14]=01; vid_page=1; port_7ffd=8'h1B, visible 1 clock after the write edge.
- OUT 7FFD with D=8'h20, then OUT 7FFD with D=8'h07 -> port_7ffd stays 8'h20; C000 maps to bank 0; locked=1. Pulse reset_n low -> port_7ffd=0, locked=0.
- OUT 1FFD with D=8'h07 (ENABLE_1FFD=1) -> mem_rom=0 everywhere; A=0000/4000/8000/C000 map to banks 4/7/6/3; write to 16'h0005 gives ram_we=1.
- RAM_BANK_BITS=5, OUT 7FFD with D=8'hC5 -> C000 maps to bank 5'b11101, mem_addr=19'h74000. With RAM_BANK_BITS=3, the same write maps to bank 5.
- FULL_DECODE=0: OUT to 16'h7FFC -> accepted as 7FFD. FULL_DECODE=1: same write ignored. nIORQ/nWR held low 40 clocks -> exactly one update. nM1=0 interrupt acknowledge -> no update.
